// File: rtl/alu_ctrl_decode_if.sv
// Handshake and payload bundle between fetch, the alu_ctrl_decode stage and execute.
// The slave modport is the decode stage's view; master is the fetch/execute side.
interface alu_ctrl_decode_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr_i;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      alu_ctrl;
  logic [XLEN-1:0] imm;
  logic            use_imm;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic            reg_we;
  logic            is_branch;
  logic            illegal;

  modport slave (
    input  in_valid, instr_i, out_ready,
    output in_ready, out_valid, alu_ctrl, imm, use_imm, rs1, rs2, rd,
           reg_we, is_branch, illegal
  );

  modport master (
    output in_valid, instr_i, out_ready,
    input  in_ready, out_valid, alu_ctrl, imm, use_imm, rs1, rs2, rd,
           reg_we, is_branch, illegal
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// RV32I decode stage: instruction word -> aluCtrl code, immediate, register indices and flags.
// Define DECODE_SKID_EN to add a skid entry so in_ready comes straight from a flop.
module alu_ctrl_decode #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  alu_ctrl_decode_if.slave bus
);

  typedef enum logic [5:0] {
    ALU_ADD  = 6'd0,  ALU_SUB  = 6'd1,  ALU_XOR  = 6'd2,  ALU_SLL  = 6'd3,
    ALU_SLT  = 6'd4,  ALU_SRL  = 6'd5,  ALU_SRA  = 6'd6,  ALU_AND  = 6'd7,
    ALU_OR   = 6'd8,  ALU_BEQ  = 6'd9,  ALU_BNE  = 6'd10, ALU_BLT  = 6'd11,
    ALU_BGE  = 6'd12, ALU_SLTU = 6'd13, ALU_BLTU = 6'd14, ALU_BGEU = 6'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  typedef struct packed {
    logic [5:0]      alu_ctrl;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_we;
    logic            is_branch;
    logic            illegal;
  } payload_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  // funct3 groups that need no funct7 disambiguation share one mapping for OP and OP-IMM
  function automatic alu_op_e plain_op(input logic [2:0] f3);
    case (f3)
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_shamt;
  payload_t        dec;

  assign instr     = bus.instr_i;
  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];
  assign imm_i     = {{20{instr[31]}}, instr[31:20]};
  assign imm_s     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u     = {instr[31:12], 12'b0};
  assign imm_j     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_shamt = {27'b0, instr[24:20]};

  // Pure decode of the incoming word; illegal and rd=0 cleanups are applied last
  always_comb begin
    dec          = '0;
    dec.alu_ctrl = ALU_ADD;
    dec.rs1      = instr[19:15];
    dec.rs2      = instr[24:20];
    dec.rd       = instr[11:7];
    case (opcode)
      OPC_OP: begin
        dec.reg_we = 1'b1;
        case (funct3)
          3'b000: begin
            if (funct7 == F7_BASE)     dec.alu_ctrl = ALU_ADD;
            else if (funct7 == F7_ALT) dec.alu_ctrl = ALU_SUB;
            else                       dec.illegal  = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_BASE)     dec.alu_ctrl = ALU_SRL;
            else if (funct7 == F7_ALT) dec.alu_ctrl = ALU_SRA;
            else                       dec.illegal  = 1'b1;
          end
          default: begin
            dec.alu_ctrl = plain_op(funct3);
            dec.illegal  = (funct7 != F7_BASE);
          end
        endcase
      end
      OPC_OP_IMM: begin
        dec.reg_we  = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = imm_i;
        case (funct3)
          3'b001: begin
            dec.alu_ctrl = ALU_SLL;
            dec.imm      = imm_shamt;
            dec.illegal  = (funct7 != F7_BASE);
          end
          3'b101: begin
            dec.imm = imm_shamt;
            if (funct7 == F7_BASE)     dec.alu_ctrl = ALU_SRL;
            else if (funct7 == F7_ALT) dec.alu_ctrl = ALU_SRA;
            else                       dec.illegal  = 1'b1;
          end
          default: dec.alu_ctrl = plain_op(funct3);
        endcase
      end
      OPC_BRANCH: begin
        dec.is_branch = 1'b1;
        dec.imm       = imm_b;
        case (funct3)
          3'b000:  dec.alu_ctrl = ALU_BEQ;
          3'b001:  dec.alu_ctrl = ALU_BNE;
          3'b100:  dec.alu_ctrl = ALU_BLT;
          3'b101:  dec.alu_ctrl = ALU_BGE;
          3'b110:  dec.alu_ctrl = ALU_BLTU;
          3'b111:  dec.alu_ctrl = ALU_BGEU;
          default: dec.illegal  = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_JALR: begin
        dec.reg_we  = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = imm_i;
      end
      OPC_STORE: begin
        dec.use_imm = 1'b1;
        dec.imm     = imm_s;
      end
      OPC_LUI: begin
        dec.reg_we  = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = imm_u;
        dec.rs1     = 5'd0;
      end
      OPC_AUIPC: begin
        dec.reg_we  = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = imm_u;
      end
      OPC_JAL: begin
        dec.reg_we  = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = imm_j;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.alu_ctrl  = ALU_ADD;
      dec.reg_we    = 1'b0;
      dec.is_branch = 1'b0;
      dec.use_imm   = 1'b0;
      dec.imm       = '0;
    end
    if (dec.rd == 5'd0) dec.reg_we = 1'b0;
  end

  occ_e     occ_q;
  occ_e     occ_d;
  payload_t out_q;
  payload_t out_d;
  logic     in_ready;
  logic     in_xfer;
  logic     out_xfer;

  assign in_xfer  = bus.in_valid && in_ready;
  assign out_xfer = (occ_q != OCC_EMPTY) && bus.out_ready;

`ifdef DECODE_SKID_EN
  payload_t skid_q;
  payload_t skid_d;

  assign in_ready = (occ_q != OCC_TWO);

  // Output entry refills from the skid first so order is preserved
  always_comb begin
    occ_d  = occ_q;
    out_d  = out_q;
    skid_d = skid_q;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: if (in_xfer) begin
          occ_d = OCC_ONE;
          out_d = dec;
        end
        OCC_ONE: begin
          if (out_xfer && in_xfer) begin
            out_d = dec;
          end else if (out_xfer) begin
            occ_d = OCC_EMPTY;
          end else if (in_xfer) begin
            occ_d  = OCC_TWO;
            skid_d = dec;
          end
        end
        OCC_TWO: if (out_xfer) begin
          occ_d = OCC_ONE;
          out_d = skid_q;
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) skid_q <= '0;
    else        skid_q <= skid_d;
  end
`else
  assign in_ready = (occ_q == OCC_EMPTY) || bus.out_ready;

  // Single entry: any in-transfer overwrites, since in_ready implies the old entry leaves
  always_comb begin
    occ_d = occ_q;
    out_d = out_q;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else if (in_xfer) begin
      occ_d = OCC_ONE;
      out_d = dec;
    end else if (out_xfer) begin
      occ_d = OCC_EMPTY;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= OCC_EMPTY;
      out_q <= '0;
    end else begin
      occ_q <= occ_d;
      out_q <= out_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (occ_q != OCC_EMPTY);
  assign bus.alu_ctrl  = out_q.alu_ctrl;
  assign bus.imm       = out_q.imm;
  assign bus.use_imm   = out_q.use_imm;
  assign bus.rs1       = out_q.rs1;
  assign bus.rs2       = out_q.rs2;
  assign bus.rd        = out_q.rd;
  assign bus.reg_we    = out_q.reg_we;
  assign bus.is_branch = out_q.is_branch;
  assign bus.illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Directed bench for alu_ctrl_decode: decode tables, handshake, backpressure, flush and reset.
// Backpressure expectations follow DECODE_SKID_EN when it is defined.
module tb_alu_ctrl_decode;

  typedef struct packed {
    logic [31:0] instr;
    logic [5:0]  alu;
    logic [31:0] imm;
    logic        use_imm;
    logic        reg_we;
    logic        is_branch;
    logic [4:0]  rd;
  } imm_vec_t;

  localparam logic [31:0] R_INSTR [10] = '{
    32'h002081B3, 32'h402081B3, 32'h002091B3, 32'h0020A1B3, 32'h0020B1B3,
    32'h0020C1B3, 32'h0020D1B3, 32'h4020D1B3, 32'h0020E1B3, 32'h0020F1B3};
  localparam logic [5:0] R_ALU [10] = '{
    6'd0, 6'd1, 6'd3, 6'd4, 6'd13, 6'd2, 6'd5, 6'd6, 6'd8, 6'd7};

  localparam imm_vec_t IMM_VECS [11] = '{
    '{32'h40335293, 6'd6,  32'h00000003, 1'b1, 1'b1, 1'b0, 5'd5},
    '{32'h41F0D093, 6'd6,  32'h0000001F, 1'b1, 1'b1, 1'b0, 5'd1},
    '{32'hFFF00093, 6'd0,  32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 5'd1},
    '{32'h40008093, 6'd0,  32'h00000400, 1'b1, 1'b1, 1'b0, 5'd1},
    '{32'h00109093, 6'd3,  32'h00000001, 1'b1, 1'b1, 1'b0, 5'd1},
    '{32'h123452B7, 6'd0,  32'h12345000, 1'b1, 1'b1, 1'b0, 5'd5},
    '{32'hFF812383, 6'd0,  32'hFFFFFFF8, 1'b1, 1'b1, 1'b0, 5'd7},
    '{32'hFE20AE23, 6'd0,  32'hFFFFFFFC, 1'b1, 1'b0, 1'b0, 5'd28},
    '{32'hFFDFF06F, 6'd0,  32'hFFFFFFFC, 1'b1, 1'b0, 1'b0, 5'd0},
    '{32'h0020F463, 6'd15, 32'h00000008, 1'b0, 1'b0, 1'b1, 5'd8},
    '{32'h0020C463, 6'd11, 32'h00000008, 1'b0, 1'b0, 1'b1, 5'd8}};

  localparam logic [31:0] ILL_INSTR [6] = '{
    32'hFFFFFFFF, 32'h022081B3, 32'h40109093, 32'h0020A463, 32'h02335293, 32'h00000000};

  // addi xk, x0, k for k = 1..4: rd and imm both identify the entry
  localparam logic [31:0] SEQ [4] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
  localparam logic [31:0] FLUSH_INSTR = 32'h00900493;

`ifdef DECODE_SKID_EN
  localparam int EXP_EXTRA = 1;
`else
  localparam int EXP_EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic acc;
  logic [4:0] delivered [$];

  alu_ctrl_decode_if #(.XLEN(32)) bus ();

  alu_ctrl_decode #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus, entered and left at a falling edge
  task automatic apply(input logic v, input logic [31:0] ins, input logic ordy,
                       input logic fl, output logic accepted);
    bus.in_valid  = v;
    bus.instr_i   = ins;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    accepted = v && bus.in_ready;
    if (bus.out_valid && ordy && !fl) delivered.push_back(bus.rd);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.instr_i = '0; bus.out_ready = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.out_valid, bus.alu_ctrl, bus.imm, bus.use_imm, bus.rs1, bus.rs2, bus.rd,
         bus.reg_we, bus.is_branch, bus.illegal} !== 58'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got out_valid=%b imm=%h rd=%0d, want all zero",
               bus.out_valid, bus.imm, bus.rd);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got in_ready,out_valid=%b, want 10",
               {bus.in_ready, bus.out_valid});
    end
  endtask

  task automatic test_alu_ops();
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, R_INSTR[i], 1'b1, 1'b0, acc);
      vectors++;
      if ({bus.out_valid, bus.alu_ctrl, bus.reg_we, bus.use_imm, bus.illegal, bus.is_branch, bus.rd}
          !== {1'b1, R_ALU[i], 1'b1, 1'b0, 1'b0, 1'b0, 5'd3}) begin
        miscompares++;
        $display("[TB] FAIL alu_op[%0d]: got alu=%0d we=%b imm_sel=%b ill=%b rd=%0d, want alu=%0d we=1 imm_sel=0 ill=0 rd=3",
                 i, bus.alu_ctrl, bus.reg_we, bus.use_imm, bus.illegal, bus.rd, R_ALU[i]);
      end
    end
    apply(1'b1, 32'h002081B3, 1'b1, 1'b0, acc);
    vectors++;
    if ({bus.rs1, bus.rs2} !== {5'd1, 5'd2}) begin
      miscompares++;
      $display("[TB] FAIL add_regs: got rs1=%0d rs2=%0d, want rs1=1 rs2=2", bus.rs1, bus.rs2);
    end
    apply(1'b1, 32'h00208033, 1'b1, 1'b0, acc);
    vectors++;
    if ({bus.out_valid, bus.reg_we, bus.rd} !== {1'b1, 1'b0, 5'd0}) begin
      miscompares++;
      $display("[TB] FAIL rd_zero_we: got valid=%b we=%b rd=%0d, want 1 0 0",
               bus.out_valid, bus.reg_we, bus.rd);
    end
  endtask

  task automatic test_imm_decode();
    for (int i = 0; i < 11; i++) begin
      apply(1'b1, IMM_VECS[i].instr, 1'b1, 1'b0, acc);
      vectors++;
      if ({bus.out_valid, bus.alu_ctrl, bus.imm, bus.use_imm, bus.reg_we, bus.is_branch, bus.illegal, bus.rd}
          !== {1'b1, IMM_VECS[i].alu, IMM_VECS[i].imm, IMM_VECS[i].use_imm, IMM_VECS[i].reg_we,
               IMM_VECS[i].is_branch, 1'b0, IMM_VECS[i].rd}) begin
        miscompares++;
        $display("[TB] FAIL imm_vec[%0d]: got alu=%0d imm=%h ui=%b we=%b br=%b ill=%b rd=%0d, want alu=%0d imm=%h ui=%b we=%b br=%b ill=0 rd=%0d",
                 i, bus.alu_ctrl, bus.imm, bus.use_imm, bus.reg_we, bus.is_branch, bus.illegal, bus.rd,
                 IMM_VECS[i].alu, IMM_VECS[i].imm, IMM_VECS[i].use_imm, IMM_VECS[i].reg_we,
                 IMM_VECS[i].is_branch, IMM_VECS[i].rd);
      end
    end
    apply(1'b1, 32'h123452B7, 1'b1, 1'b0, acc);
    vectors++;
    if (bus.rs1 !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL lui_rs1: got %0d, want 0", bus.rs1);
    end
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, ILL_INSTR[i], 1'b1, 1'b0, acc);
      vectors++;
      if ({bus.out_valid, bus.illegal, bus.alu_ctrl, bus.reg_we, bus.is_branch}
          !== {1'b1, 1'b1, 6'd0, 1'b0, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL illegal[%0d] %h: got valid=%b ill=%b alu=%0d we=%b br=%b, want 1 1 0 0 0",
                 i, ILL_INSTR[i], bus.out_valid, bus.illegal, bus.alu_ctrl, bus.reg_we, bus.is_branch);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply(1'b0, 32'h0, 1'b1, 1'b0, acc);
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, SEQ[i], 1'b1, 1'b0, acc);
      vectors++;
      if ({acc, bus.out_valid, bus.rd} !== {1'b1, 1'b1, 5'(i + 1)}) begin
        miscompares++;
        $display("[TB] FAIL b2b[%0d]: got acc=%b valid=%b rd=%0d, want 1 1 %0d",
                 i, acc, bus.out_valid, bus.rd, i + 1);
      end
    end
    apply(1'b0, 32'h0, 1'b1, 1'b0, acc);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_drain: got out_valid=%b, want 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    int extra = 0;
    int idx;
    int budget = 20;
    delivered.delete();
    apply(1'b1, SEQ[0], 1'b0, 1'b0, acc);
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, SEQ[1], 1'b0, 1'b0, acc);
      if (acc) extra++;
      vectors++;
      if ({bus.out_valid, bus.in_ready, bus.rd, bus.imm} !== {1'b1, 1'b0, 5'd1, 32'd1}) begin
        miscompares++;
        $display("[TB] FAIL stall[%0d]: got valid=%b in_ready=%b rd=%0d imm=%h, want 1 0 1 00000001",
                 k, bus.out_valid, bus.in_ready, bus.rd, bus.imm);
      end
    end
    vectors++;
    if (extra !== EXP_EXTRA) begin
      miscompares++;
      $display("[TB] FAIL stall_accepts: got %0d extra, want %0d", extra, EXP_EXTRA);
    end
    idx = 1 + extra;
    while (delivered.size() < 4 && budget > 0) begin
      apply(idx < 4, SEQ[(idx < 4) ? idx : 0], 1'b1, 1'b0, acc);
      if (acc) idx++;
      budget--;
    end
    vectors++;
    if (delivered.size() != 4) begin
      miscompares++;
      $display("[TB] FAIL release_count: got %0d delivered, want 4", delivered.size());
    end
    for (int i = 0; i < delivered.size(); i++) begin
      vectors++;
      if (delivered[i] !== 5'(i + 1)) begin
        miscompares++;
        $display("[TB] FAIL release_order[%0d]: got rd=%0d, want %0d", i, delivered[i], i + 1);
      end
    end
  endtask

  task automatic test_flush();
    int nines = 0;
    apply(1'b1, SEQ[0], 1'b0, 1'b0, acc);
    delivered.delete();
    apply(1'b1, FLUSH_INSTR, 1'b0, 1'b1, acc);
    vectors++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL flush_stalled: got out_valid,in_ready=%b, want 01", {bus.out_valid, bus.in_ready});
    end
    apply(1'b1, SEQ[1], 1'b1, 1'b0, acc);
    apply(1'b1, FLUSH_INSTR, 1'b1, 1'b1, acc);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_flowing: got out_valid=%b, want 0", bus.out_valid);
    end
    repeat (3) apply(1'b0, 32'h0, 1'b1, 1'b0, acc);
    foreach (delivered[i]) if (delivered[i] == 5'd9) nines++;
    vectors++;
    if ({bus.out_valid, 8'(nines)} !== 9'd0) begin
      miscompares++;
      $display("[TB] FAIL flush_discard: got out_valid=%b flushed_seen=%0d, want 0 0", bus.out_valid, nines);
    end
  endtask

  task automatic test_reset_midstream();
    apply(1'b1, 32'h123452B7, 1'b0, 1'b0, acc);
    bus.in_valid = 1'b1;
    bus.instr_i  = SEQ[2];
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.out_valid, bus.alu_ctrl, bus.imm, bus.use_imm, bus.rs1, bus.rs2, bus.rd,
         bus.reg_we, bus.is_branch, bus.illegal} !== 58'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid: got out_valid=%b imm=%h rd=%0d, want all zero",
               bus.out_valid, bus.imm, bus.rd);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, 32'h0, 1'b1, 1'b0, acc);
    vectors++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_release: got out_valid,in_ready=%b, want 01", {bus.out_valid, bus.in_ready});
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_imm_decode();
    test_illegal();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
